// File: rtl/rbm_pkg.sv
// Shared types and default sizes for the RBM inference sequencer.
// Defaults match the Main core build.
package rbm_pkg;

  localparam int N_VIS_D = 784;
  localparam int N_HID_D = 441;
  localparam int N_CLS_D = 10;
  localparam int W_D     = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HID_FEED,
    S_HID_CAP,
    S_CLS_FEED,
    S_CLS_CAP,
    S_ARGMAX,
    S_DONE
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rbm_sequencer_if.sv
// Host handshake and result readback for the RBM sequencer.
// The slave side is the sequencer, the master side the host.
interface rbm_sequencer_if
  import rbm_pkg::*;
#(
  parameter int ITER_W = 8,
  parameter int CNT_W  = 8,
  parameter int K_W    = idx_w(N_CLS_D)
);

  logic              start;
  logic [ITER_W-1:0] iter_num;
  logic              busy;
  logic              done;
  logic [K_W-1:0]    result_class;
  logic [CNT_W-1:0]  result_count;
  logic [K_W-1:0]    cnt_rd_idx;
  logic [CNT_W-1:0]  cnt_rd_data;

  modport master (
    output start, iter_num, cnt_rd_idx,
    input  busy, done, result_class,
    input  result_count, cnt_rd_data
  );

  modport slave (
    input  start, iter_num, cnt_rd_idx,
    output busy, done, result_class,
    output result_count, cnt_rd_data
  );

endinterface

// File: rtl/rbm_class_counter.sv
// Per-class saturating spike counters with a one-class-per-cycle
// argmax scan; ties keep the lowest index.
module rbm_class_counter
  import rbm_pkg::*;
#(
  parameter  int N_CLS = N_CLS_D,
  parameter  int CNT_W = 8,
  localparam int K_W   = idx_w(N_CLS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [K_W-1:0]   inc_idx_i,
  input  logic             spike_i,
  input  logic             scan_i,
  input  logic [K_W-1:0]   scan_idx_i,
  input  logic [K_W-1:0]   rd_idx_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [K_W-1:0]   res_class_o,
  output logic [CNT_W-1:0] res_count_o
);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_CLS - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] cnt_q [N_CLS];
  logic [CNT_W-1:0] cnt_d [N_CLS];
  logic [K_W-1:0]   best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [K_W-1:0]   res_cls_q, res_cls_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] scan_val;
  logic             take;
  logic [K_W-1:0]   win_idx;
  logic [CNT_W-1:0] win_cnt;

  assign scan_val = cnt_q[scan_idx_i];
  assign take = (scan_idx_i == '0) ||
                (scan_val > best_cnt_q);
  assign win_idx = take ? scan_idx_i : best_idx_q;
  assign win_cnt = take ? scan_val : best_cnt_q;

  always_comb begin
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    res_cls_d  = res_cls_q;
    res_cnt_d  = res_cnt_q;
    if (clr_i) begin
      for (int i = 0; i < N_CLS; i++)
        cnt_d[i] = '0;
    end else if (inc_i && spike_i &&
                 inc_idx_i <= K_LAST &&
                 cnt_q[inc_idx_i] != C_MAX) begin
      cnt_d[inc_idx_i] =
        cnt_q[inc_idx_i] + CNT_W'(1);
    end
    if (scan_i) begin
      best_idx_d = win_idx;
      best_cnt_d = win_cnt;
      if (scan_idx_i == K_LAST) begin
        res_cls_d = win_idx;
        res_cnt_d = win_cnt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '{default: '0};
      best_idx_q <= '0;
      best_cnt_q <= '0;
      res_cls_q  <= '0;
      res_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      res_cls_q  <= res_cls_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign rd_data_o = (rd_idx_i <= K_LAST) ?
                     cnt_q[rd_idx_i] : '0;
  assign res_class_o = res_cls_q;
  assign res_count_o = res_cnt_q;

endmodule

// File: rtl/rbm_sequencer.sv
// Drives the Main RBM core through hidden and classifier phases
// for a runtime number of iterations, then reports the argmax class.
module rbm_sequencer
  import rbm_pkg::*;
#(
  parameter  int N_VIS  = N_VIS_D,
  parameter  int N_HID  = N_HID_D,
  parameter  int N_CLS  = N_CLS_D,
  parameter  int W      = W_D,
  parameter  int ITER_W = 8,
  parameter  int CNT_W  = 8,
  localparam int IMG_AW = idx_w(N_VIS),
  localparam int HV_W   = idx_w(N_VIS + 1),
  localparam int HH_W   = idx_w(N_HID),
  localparam int CH_W   = idx_w(N_HID + 1),
  localparam int K_W    = idx_w(N_CLS),
  localparam int PID_W  = idx_w(N_VIS + 2),
  localparam int HID_W  = idx_w(N_HID + 2)
) (
  input  logic              clock,
  input  logic              reset,
  rbm_sequencer_if.slave    host,
  output logic [IMG_AW-1:0] img_addr,
  input  logic              img_bit,
  output logic [HV_W-1:0]   h_addr_v,
  output logic [HH_W-1:0]   h_addr_h,
  input  logic [W-1:0]      h_data,
  input  logic              sw_in,
  output logic [CH_W-1:0]   c_addr_h,
  output logic [K_W-1:0]    c_addr_k,
  input  logic [W-1:0]      c_data,
  output logic [W-1:0]      core_hvalue,
  output logic [PID_W-1:0]  core_pixel_id,
  output logic              core_pixel,
  output logic              core_switch,
  output logic              core_en_hidden,
  output logic              core_en_classi,
  output logic [W-1:0]      core_cvalue,
  output logic [HID_W-1:0]  core_hidden_id,
  output logic              core_hidden_pixel,
  input  logic              core_hidden,
  input  logic              core_spike
);

  localparam logic [HV_W-1:0] V_BIAS = HV_W'(N_VIS);
  localparam logic [CH_W-1:0] H_LAST = CH_W'(N_HID - 1);
  localparam logic [CH_W-1:0] H_BIAS = CH_W'(N_HID);
  localparam logic [K_W-1:0]  K_LAST = K_W'(N_CLS - 1);

  state_e            state_q, state_d;
  logic [HV_W-1:0]   v_q, v_d;
  logic [CH_W-1:0]   h_q, h_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ITER_W-1:0] it_q, it_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [N_HID-1:0]  hbuf_q, hbuf_d;
  logic [ITER_W-1:0] it_nxt;
  logic              start_acc;
  logic              hid_ph;
  logic              cls_ph;

  assign it_nxt = it_q + ITER_W'(1);

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    h_d       = h_q;
    k_d       = k_q;
    it_d      = it_q;
    iter_d    = iter_q;
    hbuf_d    = hbuf_q;
    start_acc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (host.start) begin
          start_acc = 1'b1;
          iter_d = (host.iter_num == '0) ?
                   ITER_W'(1) : host.iter_num;
          v_d     = '0;
          h_d     = '0;
          k_d     = '0;
          it_d    = '0;
          state_d = S_HID_FEED;
        end
      end
      S_HID_FEED: begin
        if (v_q == V_BIAS) state_d = S_HID_CAP;
        else v_d = v_q + HV_W'(1);
      end
      S_HID_CAP: begin
        hbuf_d[h_q[HH_W-1:0]] = core_hidden;
        v_d = '0;
        if (h_q == H_LAST) begin
          h_d     = '0;
          state_d = S_CLS_FEED;
        end else begin
          h_d     = h_q + CH_W'(1);
          state_d = S_HID_FEED;
        end
      end
      S_CLS_FEED: begin
        if (h_q == H_BIAS) state_d = S_CLS_CAP;
        else h_d = h_q + CH_W'(1);
      end
      S_CLS_CAP: begin
        h_d = '0;
        if (k_q == K_LAST) begin
          k_d  = '0;
          it_d = it_nxt;
          state_d = (it_nxt == iter_q) ?
                    S_ARGMAX : S_HID_FEED;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_CLS_FEED;
        end
      end
      S_ARGMAX: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      h_q     <= '0;
      k_q     <= '0;
      it_q    <= '0;
      iter_q  <= '0;
      hbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      h_q     <= h_d;
      k_q     <= k_d;
      it_q    <= it_d;
      iter_q  <= iter_d;
      hbuf_q  <= hbuf_d;
    end
  end

  assign hid_ph = (state_q == S_HID_FEED) ||
                  (state_q == S_HID_CAP);
  assign cls_ph = (state_q == S_CLS_FEED) ||
                  (state_q == S_CLS_CAP);

  assign core_en_hidden = (state_q == S_HID_FEED);
  assign core_en_classi = (state_q == S_CLS_FEED);

  // Bias row has no image pixel; keep the image address in range.
  assign img_addr = (core_en_hidden && v_q != V_BIAS) ?
                    v_q[IMG_AW-1:0] : '0;
  assign h_addr_v = v_q;
  assign h_addr_h = hid_ph ? h_q[HH_W-1:0] : '0;
  assign c_addr_h = cls_ph ? h_q : '0;
  assign c_addr_k = cls_ph ? k_q : '0;

  assign core_hvalue   = h_data;
  assign core_cvalue   = c_data;
  assign core_switch   = sw_in;
  assign core_pixel_id = PID_W'(v_q);
  assign core_pixel    = core_en_hidden &
                         ((v_q == V_BIAS) | img_bit);

  assign core_hidden_id    = cls_ph ? HID_W'(h_q) : '0;
  assign core_hidden_pixel = core_en_classi &
    ((h_q == H_BIAS) | hbuf_q[h_q[HH_W-1:0]]);

  assign host.busy = (state_q != S_IDLE) &&
                     (state_q != S_DONE);
  assign host.done = (state_q == S_DONE);

  rbm_class_counter #(
    .N_CLS (N_CLS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i       (clock),
    .rst_i       (reset),
    .clr_i       (start_acc),
    .inc_i       (state_q == S_CLS_CAP),
    .inc_idx_i   (k_q),
    .spike_i     (core_spike),
    .scan_i      (state_q == S_ARGMAX),
    .scan_idx_i  (k_q),
    .rd_idx_i    (host.cnt_rd_idx),
    .rd_data_o   (host.cnt_rd_data),
    .res_class_o (host.result_class),
    .res_count_o (host.result_count)
  );

endmodule

// File: tb/tb_rbm_sequencer.sv
// Bench for rbm_sequencer: a stub Main core sums weighted inputs,
// and a per-image arithmetic model predicts counts and argmax.
module tb_rbm_sequencer;

  localparam int NV = 4;
  localparam int NH = 3;
  localparam int NC = 3;
  localparam int WW = 8;
  localparam int IW = 4;
  localparam int CW = 3;
  localparam int IMG_AW = $clog2(NV);
  localparam int HV_W   = $clog2(NV + 1);
  localparam int HH_W   = $clog2(NH);
  localparam int CH_W   = $clog2(NH + 1);
  localparam int K_W    = $clog2(NC);
  localparam int PID_W  = $clog2(NV + 2);
  localparam int HID_W  = $clog2(NH + 2);
  localparam int NZH    = 16 * NH;
  localparam int NZC    = 16 * NC;
  localparam int CMAX   = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run_clr = 1'b0;

  always #5 clock = ~clock;

  logic [IMG_AW-1:0] img_addr;
  logic              img_bit;
  logic [HV_W-1:0]   h_addr_v;
  logic [HH_W-1:0]   h_addr_h;
  logic [WW-1:0]     h_data;
  logic              sw_in;
  logic [CH_W-1:0]   c_addr_h;
  logic [K_W-1:0]    c_addr_k;
  logic [WW-1:0]     c_data;
  logic [WW-1:0]     core_hvalue;
  logic [PID_W-1:0]  core_pixel_id;
  logic              core_pixel;
  logic              core_switch;
  logic              core_en_hidden;
  logic              core_en_classi;
  logic [WW-1:0]     core_cvalue;
  logic [HID_W-1:0]  core_hidden_id;
  logic              core_hidden_pixel;
  logic              core_hidden;
  logic              core_spike;

  rbm_sequencer_if #(
    .ITER_W (IW), .CNT_W (CW), .K_W (K_W)
  ) host ();

  rbm_sequencer #(
    .N_VIS (NV), .N_HID (NH), .N_CLS (NC),
    .W (WW), .ITER_W (IW), .CNT_W (CW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .host              (host),
    .img_addr          (img_addr),
    .img_bit           (img_bit),
    .h_addr_v          (h_addr_v),
    .h_addr_h          (h_addr_h),
    .h_data            (h_data),
    .sw_in             (sw_in),
    .c_addr_h          (c_addr_h),
    .c_addr_k          (c_addr_k),
    .c_data            (c_data),
    .core_hvalue       (core_hvalue),
    .core_pixel_id     (core_pixel_id),
    .core_pixel        (core_pixel),
    .core_switch       (core_switch),
    .core_en_hidden    (core_en_hidden),
    .core_en_classi    (core_en_classi),
    .core_cvalue       (core_cvalue),
    .core_hidden_id    (core_hidden_id),
    .core_hidden_pixel (core_hidden_pixel),
    .core_hidden       (core_hidden),
    .core_spike        (core_spike)
  );

  // memories
  logic img [NV];
  int   hw  [NV+1][NH];
  logic sw  [NH];
  int   cw  [NH+1][NC];
  logic nz_h [NZH];
  logic nz_c [NZC];

  assign img_bit = img[img_addr];
  assign h_data = (int'(h_addr_v) <= NV && int'(h_addr_h) < NH) ?
                  WW'(hw[h_addr_v][h_addr_h]) : '0;
  assign sw_in = (int'(h_addr_h) < NH) ? sw[h_addr_h] : 1'b0;
  assign c_data = (int'(c_addr_h) <= NH && int'(c_addr_k) < NC) ?
                  WW'(cw[c_addr_h][c_addr_k]) : '0;

  // stub Main core
  logic signed [15:0]   acc_h, acc_c;
  logic signed [WW-1:0] hv_s, cv_s;
  logic en_h_d, en_c_d, sw_l;
  int   hidx, cidx;

  assign hv_s = core_hvalue;
  assign cv_s = core_cvalue;

  always @(posedge clock) begin
    if (reset || run_clr) begin
      acc_h <= '0; acc_c <= '0;
      hidx <= 0; cidx <= 0;
      en_h_d <= 1'b0; en_c_d <= 1'b0; sw_l <= 1'b0;
    end else begin
      en_h_d <= core_en_hidden;
      en_c_d <= core_en_classi;
      if (core_en_hidden) begin
        sw_l <= core_switch;
        if (core_pixel) acc_h <= acc_h + 16'(hv_s);
      end else if (en_h_d) begin
        acc_h <= '0;
        hidx <= hidx + 1;
      end
      if (core_en_classi) begin
        if (core_hidden_pixel) acc_c <= acc_c + 16'(cv_s);
      end else if (en_c_d) begin
        acc_c <= '0;
        cidx <= cidx + 1;
      end
    end
  end

  assign core_hidden = (acc_h > 0) ^ sw_l ^
                       ((hidx < NZH) ? nz_h[hidx] : 1'b0);
  assign core_spike = (acc_c > 0) ^
                      ((cidx < NZC) ? nz_c[cidx] : 1'b0);

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int overlap = 0;

  always @(negedge clock) begin
    if (host.done) done_seen <= done_seen + 1;
    if (core_en_hidden && core_en_classi)
      overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int exp_cnt [NC];
  int exp_cls;
  int exp_max;

  task automatic model(input int iters);
    int s;
    logic hid [NH];
    for (int k = 0; k < NC; k++) exp_cnt[k] = 0;
    for (int it = 0; it < iters; it++) begin
      for (int h = 0; h < NH; h++) begin
        s = hw[NV][h];
        for (int v = 0; v < NV; v++)
          if (img[v]) s += hw[v][h];
        hid[h] = (s > 0) ^ sw[h] ^ nz_h[it*NH + h];
      end
      for (int k = 0; k < NC; k++) begin
        s = cw[NH][k];
        for (int h = 0; h < NH; h++)
          if (hid[h]) s += cw[h][k];
        if ((s > 0) ^ nz_c[it*NC + k]) exp_cnt[k]++;
      end
    end
    exp_cls = 0;
    for (int k = 0; k < NC; k++) begin
      if (exp_cnt[k] > CMAX) exp_cnt[k] = CMAX;
      if (exp_cnt[k] > exp_cnt[exp_cls]) exp_cls = k;
    end
    exp_max = exp_cnt[exp_cls];
  endtask

  // mode 0 random, 1 all classes spike, 2 class 0 always spikes
  task automatic load(input int mode);
    for (int v = 0; v < NV; v++)
      img[v] = 1'($urandom_range(0, 1));
    for (int v = 0; v <= NV; v++)
      for (int h = 0; h < NH; h++)
        hw[v][h] = int'($urandom_range(0, 40)) - 20;
    for (int h = 0; h < NH; h++)
      sw[h] = 1'($urandom_range(0, 1));
    for (int h = 0; h <= NH; h++)
      for (int k = 0; k < NC; k++)
        cw[h][k] = (mode == 0) ?
                   int'($urandom_range(0, 40)) - 20 : 0;
    for (int i = 0; i < NZH; i++)
      nz_h[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < NZC; i++) begin
      nz_c[i] = 1'($urandom_range(0, 1));
      if (mode == 1) nz_c[i] = 1'b1;
      if (mode == 2 && (i % NC) == 0) nz_c[i] = 1'b1;
    end
  endtask

  task automatic run(input int iter_in, input bit hold);
    int it_eff, lat, c;
    it_eff = (iter_in == 0) ? 1 : iter_in;
    model(it_eff);
    lat = it_eff * (NH*(NV+2) + NC*(NH+2)) + NC + 1;
    @(negedge clock); run_clr = 1'b1;
    @(negedge clock); run_clr = 1'b0;
    host.iter_num = IW'(iter_in);
    host.start = 1'b1;
    @(posedge clock); #1;
    if (!hold) host.start = 1'b0;
    c = 1;
    chk("busy_run", host.busy, 1);
    while (!host.done && c < 4000) begin
      @(posedge clock); #1;
      c++;
    end
    chk("latency", c, lat);
    chk("result_class", host.result_class, exp_cls);
    chk("result_count", host.result_count, exp_max);
    for (int k = 0; k < NC; k++) begin
      host.cnt_rd_idx = K_W'(k);
      #1;
      chk("cnt_rd", host.cnt_rd_data, exp_cnt[k]);
    end
    chk("busy_at_done", host.busy, 0);
    @(posedge clock); #1;
    chk("done_pulse", host.done, 0);
    chk("idle_after", host.busy, 0);
    if (hold) begin
      @(posedge clock); #1;
      chk("restart_next", host.busy, 1);
      host.start = 1'b0;
    end
  endtask

  initial begin
    int c, d0;
    host.start = 1'b0;
    host.iter_num = '0;
    host.cnt_rd_idx = '0;
    load(0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", host.busy, 0);
    chk("rst_done", host.done, 0);
    chk("rst_class", host.result_class, 0);
    chk("rst_count", host.result_count, 0);
    chk("rst_cnt", host.cnt_rd_data, 0);
    chk("rst_en_h", core_en_hidden, 0);
    chk("rst_en_c", core_en_classi, 0);
    chk("rst_haddr", h_addr_v, 0);
    @(negedge clock); reset = 1'b0;

    load(0); run(1, 1'b0);
    load(0); run(0, 1'b0);
    load(0); run(3, 1'b0);
    load(2); run(12, 1'b0);
    load(1); run(3, 1'b0);
    repeat (3) begin
      load(0);
      run(int'($urandom_range(1, 15)), 1'b0);
    end

    // start held through the run, then abort mid hidden feed
    load(0);
    @(negedge clock); run_clr = 1'b1;
    @(negedge clock); run_clr = 1'b0;
    d0 = done_seen;
    host.iter_num = IW'(2);
    host.start = 1'b1;
    repeat (20) @(negedge clock);
    chk("busy_hold", host.busy, 1);
    c = 0;
    while (!core_en_hidden && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("in_feed", core_en_hidden, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", host.busy, 0);
    chk("abort_done", host.done, 0);
    chk("abort_en_h", core_en_hidden, 0);
    chk("abort_img", img_addr, 0);
    chk("abort_class", host.result_class, 0);
    chk("abort_count", host.result_count, 0);
    chk("abort_cnt", host.cnt_rd_data, 0);
    host.start = 1'b0;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_no_done", done_seen - d0, 0);

    load(0); run(4, 1'b0);
    load(0); run(2, 1'b1);

    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("en_exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rbm_sequencer.md
Name: rbm_sequencer

Overview:
Parametrised on-chip controller that drives the existing `Main` RBM core through full inference and replaces the bench-level state machine.
- Hidden phase: streams visible pixels, hidden weights and biases into the core and buffers the sampled hidden bits.
- Classifier phase: streams the buffered hidden bits, classifier weights and biases into the core.
- Counts output spikes per class over a runtime-selected number of stochastic iterations, then reports the argmax class.
- Sits between the image/weight/order memories and `Main`, with a start/busy/done handshake towards the host.

Parameters:
- N_VIS, 784, visible units (image pixels)
- N_HID, 441, hidden units
- N_CLS, 10, classes
- W, 12, weight/bias width
- ITER_W, 8, width of runtime iteration count
- CNT_W, 8, per-class spike counter width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin inference; accepted only in IDLE
- iter_num  in  ITER_W  iterations; sampled on the start-accept cycle; 0 treated as 1
- busy  out  1  high from the cycle after start-accept until done
- done  out  1  one-cycle pulse; result valid
- result_class  out  clog2(N_CLS)  argmax class; held until next start
- result_count  out  CNT_W  spike count of result_class
- cnt_rd_idx  in  clog2(N_CLS)  readback select
- cnt_rd_data  out  CNT_W  combinational count of class cnt_rd_idx
- img_addr  out  clog2(N_VIS)  image memory address; combinational-read memory
- img_bit  in  1  pixel value at img_addr
- h_addr_v  out  clog2(N_VIS+1)  hidden weight row; value N_VIS selects bias
- h_addr_h  out  clog2(N_HID)  hidden weight column / bias index / order index
- h_data  in  W  HiddenWeight[v][h], or HiddenBias[h] when v==N_VIS
- sw_in  in  1  criticality switch for hidden index h_addr_h
- c_addr_h  out  clog2(N_HID+1)  classifier row; value N_HID selects bias
- c_addr_k  out  clog2(N_CLS)  class index
- c_data  in  W  ClassiWeight[h][k], or ClassiBias[k] when h==N_HID
- core_hvalue  out  W  to Main Hvalue (= h_data)
- core_pixel_id  out  clog2(N_VIS+2)  to Main pixel_id
- core_pixel  out  1  to Main pixel
- core_switch  out  1  to Main switch (= sw_in)
- core_en_hidden  out  1
- core_en_classi  out  1
- core_cvalue  out  W  to Main Cvalue (= c_data)
- core_hidden_id  out  clog2(N_HID+2)
- core_hidden_pixel  out  1
- core_hidden  in  1  sampled hidden bit from Main
- core_spike  in  1  sampled spike from Main

Behaviour:
- Reset: state IDLE; busy=0, done=0, result_class=0, result_count=0, all counters and the hidden buffer 0, core enables 0, all addresses 0.
- IDLE: start=1 → clear counters, latch iter_num (0→1), v=h=k=it=0 → HID_FEED.
- HID_FEED (en_hidden=1): h_addr_v=v, pixel_id=v.
  - core_pixel=img_bit for v<N_VIS; core_pixel=1 for v==N_VIS (bias).
  - v increments each cycle; after v==N_VIS → HID_CAP.
- HID_CAP: hbuf[h]<=core_hidden.
  - h<N_HID-1: h++, v=0 → HID_FEED.
  - Else: h=0 → CLS_FEED.
- CLS_FEED (en_classi=1): c_addr_h=core_hidden_id=h.
  - core_hidden_pixel=hbuf[h] for h<N_HID; =1 for h==N_HID.
  - After h==N_HID → CLS_CAP.
- CLS_CAP: cnt[k] += core_spike, saturating at 2^CNT_W-1.
  - k<N_CLS-1: k++, h=0 → CLS_FEED.
  - Else: it++, k=0. If it==iter → ARGMAX, else → HID_FEED with v=h=0.
- ARGMAX: one class scanned per cycle (N_CLS cycles). Strict greater-than compare, so ties resolve to the lowest index → DONE.
- DONE: done=1 for one cycle; result registers updated; busy=0 → IDLE.
- Core enables are never both 1; both are 0 outside the feed/cap states.
- Latency from start-accept: ITER·(N_HID·(N_VIS+2) + N_CLS·(N_HID+2)) + N_CLS + 1 cycles to done.
- start while busy is ignored. A start coincident with the done cycle is ignored; start is accepted on the next IDLE cycle.
- reset mid-run aborts to IDLE the same cycle; no done pulse.
- cnt_rd_data is live during a run and stable after done.

Decomposition:
- Package rbm_pkg: state enum (IDLE, HID_FEED, HID_CAP, CLS_FEED, CLS_CAP, ARGMAX, DONE), $clog2-derived index widths, and default N_VIS/N_HID/N_CLS/W constants shared with `Main`.
- Sub-module rbm_class_counter: N_CLS saturating counters, clear, increment-by-index, readback mux, and sequential argmax scan with result registers.

Test Plan:
- Smoke (N_VIS=4, N_HID=3, N_CLS=2, iter_num=1, stub core with spike=1 on class 1 only) → done at cycle 31 after accept; result_class=1, result_count=1.
- Hidden buffer (stub hidden bits 1,0,1) → core_hidden_pixel sequence per class is 1,0,1,1 (bias); core_pixel is 1 at pixel_id=N_VIS.
- Iterations/saturation (CNT_W=2, iter_num=5, spike=1 on class 0) → cnt[0]=3 (saturated), cnt[1]=0, result_class=0; iter_num=0 behaves as 1.
- Tie (both classes spike every iteration, iter_num=3) → result_class=0, result_count=3.
- start held during busy, then reset asserted mid-HID_FEED → no restart and no done pulse; all outputs return to reset values next cycle; a fresh start completes normally.
- Full-size default parameters with the real model files and image_2, iter_num=10 → per-class counts match the golden bench output; done at the computed latency.
